// File: rtl/maze_pkg.sv
// Shared types and widths for the maze Q-learning episode controller.
package maze_pkg;

  localparam int unsigned STATE_W  = 6;
  localparam int unsigned REWARD_W = 16;

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_DOWN  = 2'd1,
    ACT_LEFT  = 2'd2,
    ACT_RIGHT = 2'd3
  } action_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ACT,
    LOOKUP,
    UPDATE,
    DONE
  } fsm_e;

endpackage

// File: rtl/maze_move.sv
// Grid transition with wall clamping; states are 1-based, row-major.
module maze_move
  import maze_pkg::*;
#(
  parameter int unsigned GRID_W = 5,
  parameter int unsigned GRID_H = 5
) (
  input  logic [STATE_W-1:0] state_i,
  input  action_e            action_i,
  output logic [STATE_W-1:0] next_state_o
);

  localparam int unsigned NCELLS = GRID_W * GRID_H;

  logic [STATE_W-1:0] idx;
  logic               top_row;
  logic               bot_row;
  logic               left_col;
  logic               right_col;

  always_comb begin
    idx       = state_i - STATE_W'(1);
    top_row   = (idx < STATE_W'(GRID_W));
    bot_row   = (idx >= STATE_W'(NCELLS - GRID_W));
    left_col  = 1'b0;
    right_col = 1'b0;
    // Column edges found by matching each row's first/last index; avoids a modulo.
    for (int unsigned i = 0; i < GRID_H; i++) begin
      if (idx == STATE_W'(i * GRID_W))              left_col  = 1'b1;
      if (idx == STATE_W'(i * GRID_W + GRID_W - 1)) right_col = 1'b1;
    end

    next_state_o = state_i;
    case (action_i)
      ACT_UP:    if (!top_row)   next_state_o = state_i - STATE_W'(GRID_W);
      ACT_DOWN:  if (!bot_row)   next_state_o = state_i + STATE_W'(GRID_W);
      ACT_LEFT:  if (!left_col)  next_state_o = state_i - STATE_W'(1);
      ACT_RIGHT: if (!right_col) next_state_o = state_i + STATE_W'(1);
      default:   next_state_o = state_i;
    endcase
  end

endmodule

// File: rtl/maze_episode_ctrl.sv
// Steps one agent through the maze: action request, move, reward lookup, Q-update handshake.
module maze_episode_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned GRID_W       = 5,
  parameter int unsigned GRID_H       = 5,
  parameter int unsigned START_STATE  = 1,
  parameter int unsigned MAX_STEPS    = 64,
  parameter int unsigned NUM_EPISODES = 1000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                act_req,
  input  logic                act_valid,
  input  logic [1:0]          act_in,
  output logic [STATE_W-1:0]  cur_state,
  output logic [STATE_W-1:0]  next_state,
  input  logic [REWARD_W-1:0] reward_in,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [1:0]          upd_action,
  output logic [REWARD_W-1:0] upd_reward,
  output logic                upd_terminal,
  output logic [CNT_W-1:0]    step_cnt,
  output logic [CNT_W-1:0]    episode_cnt,
  output logic                done
);

  localparam logic [STATE_W-1:0] START_S   = STATE_W'(START_STATE);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(MAX_STEPS - 1);
  localparam logic [CNT_W-1:0]   LAST_EP   = CNT_W'(NUM_EPISODES - 1);

  fsm_e                state_q, state_d;
  logic [STATE_W-1:0]  cur_q, cur_d;
  logic [STATE_W-1:0]  nxt_q, nxt_d;
  action_e             act_q, act_d;
  logic [REWARD_W-1:0] rew_q, rew_d;
  logic                term_q, term_d;
  logic [CNT_W-1:0]    step_q, step_d;
  logic [CNT_W-1:0]    ep_q, ep_d;
  logic [STATE_W-1:0]  move_ns;

  maze_move #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_move (
    .state_i      (cur_q),
    .action_i     (action_e'(act_in)),
    .next_state_o (move_ns)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= START_S;
      nxt_q   <= START_S;
      act_q   <= ACT_UP;
      rew_q   <= '0;
      term_q  <= 1'b0;
      step_q  <= '0;
      ep_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      act_q   <= act_d;
      rew_q   <= rew_d;
      term_q  <= term_d;
      step_q  <= step_d;
      ep_q    <= ep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    act_d   = act_q;
    rew_d   = rew_q;
    term_d  = term_q;
    step_d  = step_q;
    ep_d    = ep_q;

    // Handshake strobes are masked by abort so they drop in the abort cycle itself.
    act_req   = (state_q == REQ_ACT) && !abort;
    upd_valid = (state_q == UPDATE) && !abort;
    done      = (state_q == DONE);

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = REQ_ACT;
            cur_d   = START_S;
            step_d  = '0;
            ep_d    = '0;
          end
        end
        REQ_ACT: begin
          if (act_valid) begin
            act_d   = action_e'(act_in);
            nxt_d   = move_ns;
            state_d = LOOKUP;
          end
        end
        LOOKUP: begin
          rew_d   = reward_in;
          term_d  = (reward_in != '0) || (step_q == LAST_STEP);
          state_d = UPDATE;
        end
        UPDATE: begin
          if (upd_ready) begin
            if (term_q) begin
              cur_d   = START_S;
              step_d  = '0;
              ep_d    = (ep_q == '1) ? ep_q : ep_q + CNT_W'(1);
              state_d = (ep_q == LAST_EP) ? DONE : REQ_ACT;
            end else begin
              cur_d   = nxt_q;
              step_d  = (step_q == '1) ? step_q : step_q + CNT_W'(1);
              state_d = REQ_ACT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cur_state    = cur_q;
  assign next_state   = nxt_q;
  assign upd_action   = act_q;
  assign upd_reward   = rew_q;
  assign upd_terminal = term_q;
  assign step_cnt     = step_q;
  assign episode_cnt  = ep_q;

endmodule

// File: tb/tb_maze_episode_ctrl.sv
// Directed scoreboard bench for maze_episode_ctrl on a 5x5 grid.
module tb_maze_episode_ctrl;

  localparam int unsigned MAXS = 10;
  localparam int unsigned NEP  = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        act_req, act_valid;
  logic [1:0]  act_in;
  logic [5:0]  cur_state, next_state;
  logic [15:0] reward_in;
  logic        upd_valid, upd_ready;
  logic [1:0]  upd_action;
  logic [15:0] upd_reward;
  logic        upd_terminal;
  logic [15:0] step_cnt, episode_cnt;
  logic        done;

  always #5 clk = ~clk;

  maze_episode_ctrl #(
    .MAX_STEPS    (MAXS),
    .NUM_EPISODES (NEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .act_req      (act_req),
    .act_valid    (act_valid),
    .act_in       (act_in),
    .cur_state    (cur_state),
    .next_state   (next_state),
    .reward_in    (reward_in),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_action   (upd_action),
    .upd_reward   (upd_reward),
    .upd_terminal (upd_terminal),
    .step_cnt     (step_cnt),
    .episode_cnt  (episode_cnt),
    .done         (done)
  );

  // Maze reward table: pit at 3, goal at 25.
  function automatic logic [15:0] reward_of(input logic [5:0] s);
    if (s == 6'd3)  return 16'hFF9C;
    if (s == 6'd25) return 16'd100;
    return 16'd0;
  endfunction

  always_comb reward_in = reward_of(next_state);

  function automatic logic [5:0] model_move(input logic [5:0] s, input logic [1:0] a);
    int r, c;
    r = (int'(s) - 1) / 5;
    c = (int'(s) - 1) % 5;
    case (a)
      2'd0:    return (r == 0) ? s : s - 6'd5;
      2'd1:    return (r == 4) ? s : s + 6'd5;
      2'd2:    return (c == 0) ? s : s - 6'd1;
      default: return (c == 4) ? s : s + 6'd1;
    endcase
  endfunction

  typedef struct packed {
    logic [5:0]  cur;
    logic [5:0]  nxt;
    logic [1:0]  act;
    logic [15:0] rew;
    logic        term;
  } tuple_t;

  tuple_t      sb[$];
  int unsigned ncmp = 0;
  int unsigned nfail = 0;
  logic [5:0]  m_cur;
  logic [15:0] m_step, m_ep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_cur_state",  cur_state, 6'd1);
    chk("rst_next_state", next_state, 6'd1);
    chk("rst_strobes", {act_req, upd_valid, done}, 3'b000);
    chk("rst_upd_fields", {upd_action, upd_reward, upd_terminal}, 19'd0);
    chk("rst_counters", {step_cnt, episode_cnt}, 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_cur = 6'd1; m_step = '0; m_ep = '0;
    @(negedge clk);
    chk("start_req", {act_req, done}, 2'b10);
    chk("start_state", {cur_state, step_cnt, episode_cnt}, {6'd1, 16'd0, 16'd0});
  endtask

  task automatic do_step(input logic [1:0] a, input int unsigned stall, input bit do_abort);
    tuple_t e, got;
    bit     seen;
    e.cur  = m_cur;
    e.nxt  = model_move(m_cur, a);
    e.act  = a;
    e.rew  = reward_of(e.nxt);
    e.term = (e.rew != 16'd0) || (m_step == 16'(MAXS - 1));
    sb.push_back(e);

    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = act_req;
    end
    chk("act_req_wait", seen, 1'b1);
    act_valid = 1'b1;
    act_in    = a;
    @(posedge clk);
    #1 act_valid = 1'b0;
    act_in = 2'($urandom_range(0, 3));

    @(negedge clk);
    chk("lookup_no_valid", {upd_valid, act_req}, 2'b00);
    @(negedge clk);
    chk("valid_latency2", upd_valid, 1'b1);
    for (int k = 0; k < 20 && !upd_valid; k++) @(negedge clk);

    got = sb.pop_front();
    chk("tuple", {cur_state, next_state, upd_action, upd_reward, upd_terminal}, got);

    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("backpressure_hold",
          {upd_valid, act_req, cur_state, next_state, upd_action, upd_reward, upd_terminal},
          {1'b1, 1'b0, got});
    end

    if (do_abort) begin
      abort = 1'b1;
      #1;
      chk("abort_drop_now", {upd_valid, act_req}, 2'b00);
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_idle", {upd_valid, act_req, done}, 3'b000);
      chk("abort_hold", {cur_state, step_cnt, episode_cnt}, {m_cur, m_step, m_ep});
      @(negedge clk);
      chk("abort_stays_idle", {upd_valid, act_req}, 2'b00);
    end else begin
      upd_ready = 1'b1;
      @(posedge clk);
      #1 upd_ready = 1'b0;
      if (got.term) begin
        m_cur = 6'd1; m_step = '0; m_ep = m_ep + 16'd1;
      end else begin
        m_cur = got.nxt; m_step = m_step + 16'd1;
      end
      @(negedge clk);
      chk("post_update", {cur_state, step_cnt, episode_cnt}, {m_cur, m_step, m_ep});
      chk("done_flag", done, (m_ep == 16'(NEP)));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    act_valid = 1'b0; act_in = 2'd0; upd_ready = 1'b0;
    m_cur = 6'd1; m_step = '0; m_ep = '0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // Action offered while idle must not be consumed.
    act_valid = 1'b1; act_in = 2'd3;
    repeat (2) @(negedge clk);
    chk("idle_ignores_act", {act_req, upd_valid, next_state}, {2'b00, 6'd1});
    act_valid = 1'b0;

    do_start();
    do_step(2'd2, 0, 1'b0);   // wall bump at 1
    do_step(2'd3, 0, 1'b0);   // 1 -> 2
    do_step(2'd3, 0, 1'b0);   // 2 -> 3 pit

    do_step(2'd1, 10, 1'b0);  // 1 -> 6, with backpressure
    do_step(2'd1, 0, 1'b0);
    do_step(2'd1, 0, 1'b0);
    do_step(2'd3, 0, 1'b0);
    do_step(2'd3, 0, 1'b0);
    do_step(2'd3, 0, 1'b0);
    do_step(2'd3, 0, 1'b0);   // -> 20
    do_step(2'd1, 0, 1'b0);   // 20 -> 25 goal

    do_step(2'd2, 0, 1'b1);   // abort in UPDATE

    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_beats_start", {act_req, episode_cnt}, {1'b0, 16'd2});

    do_start();
    for (int i = 0; i < int'(MAXS); i++) do_step(2'd2, 0, 1'b0);  // step limit
    do_step(2'd3, 0, 1'b0);
    do_step(2'd3, 0, 1'b0);
    do_step(2'd3, 0, 1'b0);
    do_step(2'd3, 0, 1'b0);   // third episode ends the run
    repeat (3) @(negedge clk);
    chk("done_holds", {done, act_req, upd_valid, episode_cnt, step_cnt}, {3'b100, 16'd3, 16'd0});

    do_start();
    for (int k = 0; k < 20 && !act_req; k++) @(negedge clk);
    act_valid = 1'b1; act_in = 2'd3;
    @(posedge clk);
    #1 act_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    begin
      int unsigned pulses;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (upd_valid) pulses++;
      end
      chk("no_valid_after_rst", pulses, 0);
    end
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
